uart_io_buffer: RTL and testbench

// - Parametrised UART I/O front end between the core's IN/OUT instructions and the serial pins.
// - Owns RX and TX ring FIFOs of configurable depth and moves 1..MAX_BYTES-byte words per request.
// - Full FIFOs are detected without losing a slot, RX overflow is flagged, and fill levels are exported.
// - Instantiated by the execute stage in place of its inline UART ring logic.

---
 rtl/uart_pkg.sv | 13 +
 rtl/sync_fifo.sv | 43 ++++
 rtl/uart_rx.sv | 55 +++++
 rtl/uart_tx.sv | 45 ++++
 rtl/uart_io_buffer.sv | 165 ++++++++++++++++
 tb/tb_uart_io_buffer.sv | 237 +++++++++++++++++++++++
 6 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART I/O front end.
package uart_pkg;
  localparam logic [7:0] UART_AA_BYTE = 8'hAA;

  typedef enum logic [1:0] {I_IDLE, I_REQ, I_CAP} in_state_t;
  typedef enum logic {O_IDLE, O_PUSH} out_state_t;
  typedef enum logic [1:0] {T_IDLE, T_READ, T_START, T_WAIT} drain_state_t;

  // Byte counts outside 1..max_bytes collapse to a single byte.
  function automatic logic [2:0] clamp_bytes(input logic [2:0] b, input int max_bytes);
    return (b == 3'd0 || int'(b) > max_bytes) ? 3'd1 : b;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Ring FIFO with AW+1-bit pointers (full without a spare slot) and 1-cycle read latency.
module sync_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic [AW:0]  count
);
  logic [W-1:0] mem [2**AW];
  logic [AW:0]  wr, rd, wr_nxt, rd_nxt;
  logic         do_push, do_pop;

  assign empty   = (wr == rd);
  assign full    = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign wr_nxt  = wr + (AW+1)'(do_push);
  assign rd_nxt  = rd + (AW+1)'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr[AW-1:0]] <= din;
    if (do_pop)  dout <= mem[rd[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr    <= '0;
      rd    <= '0;
      count <= '0;
    end else begin
      wr    <= wr_nxt;
      rd    <= rd_nxt;
      count <= wr_nxt - rd_nxt;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first; one-cycle ready pulse with data held until the next byte.
module uart_rx #(
  parameter int CLK_PER_HALF_BIT = 434
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic       ready,
  output logic [7:0] data
);
  localparam int CW = $clog2(3 * CLK_PER_HALF_BIT);
  localparam logic [CW-1:0] FIRST_LAST = CW'(3 * CLK_PER_HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST   = CW'(2 * CLK_PER_HALF_BIT - 1);

  logic [1:0]    sync;
  logic          busy;
  logic [CW-1:0] cnt;
  logic [3:0]    nbit;
  logic [7:0]    sh;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync  <= 2'b11;
      busy  <= 1'b0;
      cnt   <= '0;
      nbit  <= '0;
      sh    <= '0;
      ready <= 1'b0;
      data  <= '0;
    end else begin
      sync  <= {sync[0], rxd};
      ready <= 1'b0;
      if (!busy) begin
        // first wait lands mid bit 0: half of start bit plus one full bit
        if (!sync[1]) begin
          busy <= 1'b1;
          cnt  <= FIRST_LAST;
          nbit <= '0;
        end
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end else if (nbit == 4'd8) begin
        busy <= 1'b0;
        if (sync[1]) begin
          ready <= 1'b1;
          data  <= sh;
        end
      end else begin
        sh   <= {sync[1], sh[7:1]};
        nbit <= nbit + 4'd1;
        cnt  <= BIT_LAST;
      end
    end
  end
endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1, LSB first; busy rises the cycle after tx_start.
module uart_tx #(
  parameter int CLK_PER_HALF_BIT = 434
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tx_start,
  input  logic [7:0] odata,
  output logic       txd,
  output logic       busy
);
  localparam int CW = $clog2(2 * CLK_PER_HALF_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(2 * CLK_PER_HALF_BIT - 1);

  logic [CW-1:0] cnt;
  logic [8:0]    sh;
  logic [3:0]    left;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      txd  <= 1'b1;
      busy <= 1'b0;
      cnt  <= '0;
      sh   <= '1;
      left <= '0;
    end else if (!busy) begin
      if (tx_start) begin
        txd  <= 1'b0;
        sh   <= {1'b1, odata};
        left <= 4'd9;
        cnt  <= BIT_LAST;
        busy <= 1'b1;
      end
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end else if (left == 4'd0) begin
      busy <= 1'b0;
    end else begin
      txd  <= sh[0];
      sh   <= {1'b1, sh[8:1]};
      left <= left - 4'd1;
      cnt  <= BIT_LAST;
    end
  end
endmodule

// File: rtl/uart_io_buffer.sv
// UART front end: RX/TX ring FIFOs plus IN/OUT word transfer and TX drain sequencing.
// state   | meaning
// I_REQ   | waiting for an RX byte, pops it when present
// I_CAP   | RX byte on FIFO output, placed into its lane
// O_PUSH  | writing the next OUT byte into the TX FIFO
// T_READ  | popping the next TX byte
// T_START | pulsing tx_start with the popped byte
// T_WAIT  | waiting for uart_tx to finish the frame
module uart_io_buffer
  import uart_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 434,
  parameter int RX_AW            = 11,
  parameter int TX_AW            = 11,
  parameter int MAX_BYTES        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rxd,
  output logic             txd,
  input  logic             rx_en,
  input  logic             in_start,
  input  logic [2:0]       in_bytes,
  output logic             in_busy,
  output logic             in_done,
  output logic [31:0]      in_data,
  input  logic             out_start,
  input  logic [2:0]       out_bytes,
  input  logic [31:0]      out_data,
  output logic             out_busy,
  output logic             out_done,
  output logic [RX_AW:0]   rx_count,
  output logic [TX_AW:0]   tx_count,
  output logic             rx_overflow,
  output logic             aa_received
);
  logic         rstn;
  logic         rx_ready, rx_push, rx_pop, rx_empty, rx_full;
  logic [7:0]   rx_byte, rx_dout;
  logic         tx_push, tx_pop, tx_empty, tx_full, tx_start, tx_busy;
  logic [7:0]   tx_din, tx_dout;
  in_state_t    in_state, in_next;
  out_state_t   out_state, out_next;
  drain_state_t tx_state, tx_next;
  logic [2:0]   in_n, in_rem, out_n, out_idx;
  logic [1:0]   in_lane;
  logic [31:0]  out_word;

  assign rstn        = ~rst;
  assign aa_received = rx_ready && (rx_byte == UART_AA_BYTE);
  assign rx_push     = rx_ready && rx_en && !rx_full;
  assign in_busy     = in_start || (in_state != I_IDLE);
  assign out_busy    = out_start || (out_state != O_IDLE);
  assign in_lane     = 2'(in_n - in_rem);
  assign tx_din      = out_word[{out_idx[1:0], 3'b000} +: 8];

  uart_rx #(.CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)) u_rx (
    .clk(clk), .rstn(rstn), .rxd(rxd), .ready(rx_ready), .data(rx_byte)
  );

  uart_tx #(.CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)) u_tx (
    .clk(clk), .rstn(rstn), .tx_start(tx_start), .odata(tx_dout), .txd(txd), .busy(tx_busy)
  );

  sync_fifo #(.W(8), .AW(RX_AW)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(rx_byte), .dout(rx_dout),
    .empty(rx_empty), .full(rx_full), .count(rx_count)
  );

  sync_fifo #(.W(8), .AW(TX_AW)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(tx_din), .dout(tx_dout),
    .empty(tx_empty), .full(tx_full), .count(tx_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      in_state    <= I_IDLE;
      out_state   <= O_IDLE;
      tx_state    <= T_IDLE;
      in_n        <= 3'd1;
      in_rem      <= '0;
      in_data     <= '0;
      in_done     <= 1'b0;
      out_n       <= 3'd1;
      out_idx     <= '0;
      out_word    <= '0;
      rx_overflow <= 1'b0;
    end else begin
      in_state  <= in_next;
      out_state <= out_next;
      tx_state  <= tx_next;
      in_done   <= 1'b0;
      if (rx_ready && rx_en && rx_full) rx_overflow <= 1'b1;
      case (in_state)
        I_IDLE: if (in_start) begin
          in_n    <= clamp_bytes(in_bytes, MAX_BYTES);
          in_rem  <= clamp_bytes(in_bytes, MAX_BYTES);
          in_data <= '0;
        end
        I_CAP: begin
          in_data[{in_lane, 3'b000} +: 8] <= rx_dout;
          in_rem  <= in_rem - 3'd1;
          in_done <= (in_rem == 3'd1);
        end
        default: ;
      endcase
      case (out_state)
        O_IDLE: if (out_start) begin
          out_word <= out_data;
          out_n    <= clamp_bytes(out_bytes, MAX_BYTES);
          out_idx  <= '0;
        end
        O_PUSH: if (!tx_full) out_idx <= out_idx + 3'd1;
      endcase
    end
  end

  always_comb begin
    in_next = in_state;
    rx_pop  = 1'b0;
    case (in_state)
      I_IDLE: if (in_start) in_next = I_REQ;
      I_REQ: if (!rx_empty) begin
        rx_pop  = 1'b1;
        in_next = I_CAP;
      end
      I_CAP:   in_next = (in_rem == 3'd1) ? I_IDLE : I_REQ;
      default: in_next = I_IDLE;
    endcase
  end

  always_comb begin
    out_next = out_state;
    tx_push  = 1'b0;
    out_done = 1'b0;
    case (out_state)
      O_IDLE: if (out_start) out_next = O_PUSH;
      O_PUSH: if (!tx_full) begin
        tx_push = 1'b1;
        if (out_idx == out_n - 3'd1) begin
          out_done = 1'b1;
          out_next = O_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    tx_next  = tx_state;
    tx_pop   = 1'b0;
    tx_start = 1'b0;
    case (tx_state)
      T_IDLE:  if (!tx_empty && !tx_busy) tx_next = T_READ;
      T_READ: begin
        tx_pop  = 1'b1;
        tx_next = T_START;
      end
      T_START: begin
        tx_start = 1'b1;
        tx_next  = T_WAIT;
      end
      T_WAIT:  if (!tx_busy) tx_next = T_IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_io_buffer.sv
// Directed bench for uart_io_buffer with a fast bit rate and a 4-deep RX FIFO.
module tb_uart_io_buffer;
  localparam int HB    = 4;
  localparam int RX_AW = 2;
  localparam int TX_AW = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           rxd = 1'b1;
  logic           rx_en = 1'b0;
  logic           in_start = 1'b0;
  logic [2:0]     in_bytes = 3'd1;
  logic           out_start = 1'b0;
  logic [2:0]     out_bytes = 3'd1;
  logic [31:0]    out_data = '0;
  logic           txd, in_busy, in_done, out_busy, out_done, rx_overflow, aa_received;
  logic [31:0]    in_data;
  logic [RX_AW:0] rx_count;
  logic [TX_AW:0] tx_count;

  int checks = 0;
  int errors = 0;
  int in_done_cnt = 0;
  int out_done_cnt = 0;
  int aa_cnt = 0;
  int tx_peak = 0;
  logic [7:0] txq[$];

  uart_io_buffer #(
    .CLK_PER_HALF_BIT(HB), .RX_AW(RX_AW), .TX_AW(TX_AW), .MAX_BYTES(4)
  ) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .txd(txd), .rx_en(rx_en),
    .in_start(in_start), .in_bytes(in_bytes), .in_busy(in_busy), .in_done(in_done),
    .in_data(in_data), .out_start(out_start), .out_bytes(out_bytes), .out_data(out_data),
    .out_busy(out_busy), .out_done(out_done), .rx_count(rx_count), .tx_count(tx_count),
    .rx_overflow(rx_overflow), .aa_received(aa_received)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (in_done === 1'b1) in_done_cnt++;
    if (out_done === 1'b1) out_done_cnt++;
    if (aa_received === 1'b1) aa_cnt++;
    if (int'(tx_count) > tx_peak) tx_peak = int'(tx_count);
  end

  // serial decoder for txd: sample at mid-bit, record each byte after bit 7
  initial begin : tx_decoder
    logic [7:0] b;
    b = '0;
    forever begin
      @(posedge clk);
      if (txd === 1'b0) begin
        repeat (HB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (2 * HB) @(posedge clk);
          b[i] = txd;
        end
        txq.push_back(b);
        repeat (2 * HB) @(posedge clk);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] txq_at(input int i);
    return (i < txq.size()) ? txq[i] : 8'hxx;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rxd = 1'b0;
    repeat (2 * HB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (2 * HB) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (4 * HB) @(negedge clk);
  endtask

  task automatic pulse_in(input logic [2:0] nb);
    @(negedge clk);
    in_bytes = nb;
    in_start = 1'b1;
    #1;
    chk("in_busy_on_start", {31'd0, in_busy}, 32'd1);
    @(negedge clk);
    in_start = 1'b0;
  endtask

  task automatic pulse_out(input logic [2:0] nb, input logic [31:0] w);
    @(negedge clk);
    out_bytes = nb;
    out_data  = w;
    out_start = 1'b1;
    #1;
    chk("out_busy_on_start", {31'd0, out_busy}, 32'd1);
    @(negedge clk);
    out_start = 1'b0;
  endtask

  initial begin
    int d0, o0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_rx_count", 32'(rx_count), 32'd0);
    chk("rst_tx_count", 32'(tx_count), 32'd0);
    chk("rst_in_busy", {31'd0, in_busy}, 32'd0);
    chk("rst_out_busy", {31'd0, out_busy}, 32'd0);
    chk("rst_in_done", {31'd0, in_done}, 32'd0);
    chk("rst_in_data", in_data, 32'd0);
    chk("rst_overflow", {31'd0, rx_overflow}, 32'd0);
    rst   = 1'b0;
    rx_en = 1'b1;

    // single byte IN
    send_byte(8'h41);
    chk("rx_count_after_41", 32'(rx_count), 32'd1);
    chk("aa_none_yet", aa_cnt, 32'd0);
    d0 = in_done_cnt;
    pulse_in(3'd1);
    repeat (10) @(negedge clk);
    chk("in1_done_pulses", in_done_cnt - d0, 32'd1);
    chk("in1_data", in_data, 32'h0000_0041);
    chk("in1_rx_count", 32'(rx_count), 32'd0);
    chk("in1_busy_clear", {31'd0, in_busy}, 32'd0);

    // four byte IN, little-endian assembly; fills the 4-deep RX FIFO exactly
    send_byte(8'h78);
    send_byte(8'h56);
    send_byte(8'h34);
    send_byte(8'h12);
    chk("rx_count_full", 32'(rx_count), 32'd4);
    chk("no_overflow_at_full", {31'd0, rx_overflow}, 32'd0);
    d0 = in_done_cnt;
    pulse_in(3'd4);
    repeat (20) @(negedge clk);
    chk("in4_done_pulses", in_done_cnt - d0, 32'd1);
    chk("in4_data", in_data, 32'h1234_5678);
    chk("in4_rx_count", 32'(rx_count), 32'd0);

    // IN on empty FIFO waits; in_bytes=0 reads one byte
    d0 = in_done_cnt;
    pulse_in(3'd0);
    repeat (20) @(negedge clk);
    chk("in_wait_busy", {31'd0, in_busy}, 32'd1);
    chk("in_wait_no_done", in_done_cnt - d0, 32'd0);
    send_byte(8'h07);
    repeat (4) @(negedge clk);
    chk("in_wait_done", in_done_cnt - d0, 32'd1);
    chk("in_wait_data", in_data, 32'h0000_0007);
    chk("in_wait_idle", {31'd0, in_busy}, 32'd0);

    // OUT of four bytes
    o0 = out_done_cnt;
    tx_peak = 0;
    txq.delete();
    pulse_out(3'd4, 32'hDEAD_BEEF);
    repeat (400) @(negedge clk);
    chk("out4_done_pulses", out_done_cnt - o0, 32'd1);
    chk("out4_tx_bytes", txq.size(), 32'd4);
    chk("out4_byte0", {24'd0, txq_at(0)}, 32'h0000_00EF);
    chk("out4_byte1", {24'd0, txq_at(1)}, 32'h0000_00BE);
    chk("out4_byte2", {24'd0, txq_at(2)}, 32'h0000_00AD);
    chk("out4_byte3", {24'd0, txq_at(3)}, 32'h0000_00DE);
    chk("out4_tx_peak", {31'd0, tx_peak >= 3 && tx_peak <= 4}, 32'd1);
    chk("out4_tx_drained", 32'(tx_count), 32'd0);

    // out_bytes above the maximum sends a single byte
    o0 = out_done_cnt;
    pulse_out(3'd7, 32'h1122_33C3);
    repeat (120) @(negedge clk);
    chk("out7_done_pulses", out_done_cnt - o0, 32'd1);
    chk("out7_tx_bytes", txq.size(), 32'd5);
    chk("out7_byte", {24'd0, txq_at(4)}, 32'h0000_00C3);

    // overflow: fifth byte dropped, AA detector fires on the fourth
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'hAA);
    send_byte(8'h55);
    chk("ovf_rx_count", 32'(rx_count), 32'd4);
    chk("ovf_flag", {31'd0, rx_overflow}, 32'd1);
    chk("aa_seen_once", aa_cnt, 32'd1);
    pulse_in(3'd2);
    repeat (12) @(negedge clk);
    chk("ovf_read_lo", in_data, 32'h0000_2211);
    pulse_in(3'd2);
    repeat (12) @(negedge clk);
    chk("ovf_read_hi", in_data, 32'h0000_AA33);
    chk("ovf_rx_count_drained", 32'(rx_count), 32'd0);
    chk("ovf_sticky", {31'd0, rx_overflow}, 32'd1);

    // rx_en low discards; high again stores one byte left for the reset check
    rx_en = 1'b0;
    send_byte(8'h99);
    chk("rx_en_off_discard", 32'(rx_count), 32'd0);
    rx_en = 1'b1;
    send_byte(8'h5A);
    chk("rx_en_on_store", 32'(rx_count), 32'd1);
    repeat (40) @(negedge clk);

    // reset in the middle of an OUT transfer
    o0 = out_done_cnt;
    pulse_out(3'd4, 32'h1122_3344);
    @(negedge clk);
    @(negedge clk);
    chk("mid_out_tx_count", 32'(tx_count), 32'd2);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_tx_count", 32'(tx_count), 32'd0);
    chk("rst_mid_rx_count", 32'(rx_count), 32'd0);
    chk("rst_mid_out_busy", {31'd0, out_busy}, 32'd0);
    chk("rst_mid_in_data", in_data, 32'd0);
    chk("rst_mid_overflow", {31'd0, rx_overflow}, 32'd0);
    chk("rst_mid_txd", {31'd0, txd}, 32'd1);
    repeat (100) @(negedge clk);
    chk("rst_mid_no_done", out_done_cnt - o0, 32'd0);
    chk("rst_mid_txd_idle", {31'd0, txd}, 32'd1);
    chk("rst_mid_tx_count_idle", 32'(tx_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
